// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_cla_adder_if
//  Purpose  : Operand/result handshake bundle for pipelined_cla_adder.
//             master = operand source / result sink, slave = the adder.
//  Revision : 1.0  initial release
// ============================================================================
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic [3:0]       flags;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, flags
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, flags
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_cla_adder
//  Purpose  : Pipelined 4-bit-group carry-lookahead adder/subtractor with a
//             valid/ready handshake and full-pipeline stall on backpressure.
//             WIDTH must be a multiple of 4 and (WIDTH/4) divisible by STAGES.
//             Optional NZCV flags: define CLA_ADDER_FLAGS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   pipelined_cla_adder_if.slave bus
);
   localparam int GPS   = (WIDTH / 4) / STAGES;  // groups per stage
   localparam int SBITS = GPS * 4;               // bits resolved per stage

   logic stall;
   logic advance;

   // One 4-bit lookahead group: returns {c4, sum[3:0]}
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic c0);
      logic [3:0] p, g;
      logic       c1, c2, c3, c4;
      p  = x ^ y;
      g  = x & y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c0);
      return {c4, p ^ {c3, c2, c1, c0}};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SBITS;   // first bit resolved here
      localparam int HI = LO + SBITS;  // bits [HI-1:0] are complete after this stage

      logic              v_in;
      logic              c_in_s;
      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic [HI-1:LO]    grp_sum;
      logic              v_d, v_q;
      logic              c_d, c_q;
      logic [HI-1:0]     s_d, s_q;

      if (k == 0) begin : g_src
         // First stage takes operands straight from the port; b inverted for subtract
         assign v_in   = bus.in_valid & bus.in_ready;
         assign c_in_s = bus.c_in;
         assign a_in   = bus.a;
         assign b_in   = bus.sub ? ~bus.b : bus.b;
         assign s_d    = grp_sum;
      end else begin : g_src
         // Later stages continue from the previous stage's registers
         assign v_in   = g_stage[k-1].v_q;
         assign c_in_s = g_stage[k-1].c_q;
         assign a_in   = g_stage[k-1].g_hold.a_q;
         assign b_in   = g_stage[k-1].g_hold.b_q;
         assign s_d    = {grp_sum, g_stage[k-1].s_q};
      end

      // Lookahead over this stage's groups, group carries chained in-stage
      always_comb begin : p_cla
         logic       c;
         logic [4:0] r;
         c       = c_in_s;
         r       = '0;
         grp_sum = '0;
         for (int j = 0; j < GPS; j++) begin
            r = cla4(a_in[LO+4*j +: 4], b_in[LO+4*j +: 4], c);
            grp_sum[LO+4*j +: 4] = r[3:0];
            c = r[4];
         end
         c_d = c;
         v_d = v_in;
      end

      // Stage valid, carry and partial sum; hold while stalled
      always_ff @(posedge clk) begin
         if (reset) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_d;
            c_q <= c_d;
            s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : g_hold
         logic [WIDTH-1:HI] a_d, a_q;
         logic [WIDTH-1:HI] b_d, b_q;
         assign a_d = a_in[WIDTH-1:HI];
         assign b_d = b_in[WIDTH-1:HI];

         // Operand bits not yet consumed travel with their partial sum
         always_ff @(posedge clk) begin
            if (reset) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

`ifdef CLA_ADDER_FLAGS_EN
      if (k == STAGES - 1) begin : g_flags
         logic [3:0] flags_d, flags_q;

         // NZCV; carry into the MSB recovered as a ^ b_eff ^ sum at bit WIDTH-1
         always_comb begin
            flags_d = {s_d[WIDTH-1], ~|s_d, c_d,
                       a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_d[WIDTH-1] ^ c_d};
         end

         // Flags registered alongside the final sum
         always_ff @(posedge clk) begin
            if (reset) begin
               flags_q <= 4'b0000;
            end else if (advance) begin
               flags_q <= flags_d;
            end
         end
      end
`endif
   end

   assign stall         = g_stage[STAGES-1].v_q & ~bus.out_ready;
   assign advance       = ~stall;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = g_stage[STAGES-1].v_q;
   assign bus.sum       = g_stage[STAGES-1].s_q;
   assign bus.c_out     = g_stage[STAGES-1].c_q;
`ifdef CLA_ADDER_FLAGS_EN
   assign bus.flags     = g_stage[STAGES-1].g_flags.flags_q;
`else
   assign bus.flags     = 4'b0000;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_cla_adder
//  Purpose  : Self-checking bench for pipelined_cla_adder (32/2, 16/4, 16/1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_cla_adder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(32)) bus32  ();
   pipelined_cla_adder_if #(.WIDTH(16)) bus16a ();
   pipelined_cla_adder_if #(.WIDTH(16)) bus16b ();

   pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) dut32  (.clk(clk), .reset(reset), .bus(bus32));
   pipelined_cla_adder #(.WIDTH(16), .STAGES(4)) dut16a (.clk(clk), .reset(reset), .bus(bus16a));
   pipelined_cla_adder #(.WIDTH(16), .STAGES(1)) dut16b (.clk(clk), .reset(reset), .bus(bus16b));

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic [3:0]  fl;
   } exp_t;

   typedef struct {
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] s;
      logic        co;
      logic [3:0]  fl;
   } vec_t;

   exp_t q[$];

   localparam int NSWEEP = 10000;
   bit          hv [NSWEEP];
   logic [16:0] hr [NSWEEP];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef CLA_ADDER_FLAGS_EN
      return f;
`else
      return 4'b0000 & f;
`endif
   endfunction

   // Reference: plain (WIDTH+1)-bit addition, flags from signed-overflow rule
   function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
      logic [31:0] be;
      logic [32:0] t;
      exp_t        e;
      be   = sub ? ~b : b;
      t    = {1'b0, a} + {1'b0, be} + 33'(cin);
      e.s  = t[31:0];
      e.co = t[32];
      e.fl = {t[31], t[31:0] == 32'd0, t[32], (a[31] == be[31]) && (t[31] != a[31])};
      return e;
   endfunction

   function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
      logic [15:0] be;
      be = sub ? ~b : b;
      return {1'b0, a} + {1'b0, be} + 17'(cin);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One handshake cycle on the 32-bit DUT with scoreboard bookkeeping
   task automatic tick32(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic ordy,
                         output logic acc);
      exp_t e;
      bus32.in_valid  = v;
      bus32.a         = a;
      bus32.b         = b;
      bus32.c_in      = cin;
      bus32.sub       = sub;
      bus32.out_ready = ordy;
      #1;
      if (bus32.out_valid && ordy) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got unexpected result 0x%0h, expected none", bus32.sum);
         end else begin
            e = q.pop_front();
            check("sb_sum",   bus32.sum,   e.s);
            check("sb_cout",  bus32.c_out, e.co);
            check("sb_flags", bus32.flags, fexp(e.fl));
         end
      end
      acc = v && bus32.in_ready;
      if (acc) q.push_back(model32(a, b, cin, sub));
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [10];
      logic        acc, hold, v, cin, sub, ordy;
      logic [31:0] ra, rb;
      logic [15:0] a16, b16;
      int          idx;

      vt[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 4'b0110};
      vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 4'b1001};
      vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 4'b1000};
      vt[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 4'b0010};
      vt[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 4'b0100};
      vt[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'b0110};
      vt[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 4'b0011};
      vt[7] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 4'b0010};
      vt[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 4'b1000};
      vt[9] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'b0110};

      bus32.in_valid = 0;  bus32.a = 0;  bus32.b = 0;  bus32.c_in = 0;  bus32.sub = 0;
      bus32.out_ready = 1;
      bus16a.in_valid = 0; bus16a.a = 0; bus16a.b = 0; bus16a.c_in = 0; bus16a.sub = 0;
      bus16a.out_ready = 1;
      bus16b.in_valid = 0; bus16b.a = 0; bus16b.b = 0; bus16b.c_in = 0; bus16b.sub = 0;
      bus16b.out_ready = 1;

      // Reset state
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_out_valid", bus32.out_valid, 1'b0);
      check("rst_in_ready",  bus32.in_ready,  1'b1);
      check("rst_sum",       bus32.sum,       32'd0);
      check("rst_cout",      bus32.c_out,     1'b0);
      check("rst_flags",     bus32.flags,     4'b0000);
      check("rst_16a_valid", bus16a.out_valid, 1'b0);
      check("rst_16b_valid", bus16b.out_valid, 1'b0);

      // Directed vectors, one at a time, with latency checks
      for (int i = 0; i < 10; i++) begin
         bus32.a = vt[i].a; bus32.b = vt[i].b; bus32.c_in = vt[i].cin; bus32.sub = vt[i].sub;
         bus32.in_valid = 1'b1;
         #1;
         check("vec_in_ready", bus32.in_ready, 1'b1);
         step();
         bus32.in_valid = 1'b0;
         check("vec_lat_early", bus32.out_valid, 1'b0);
         step();
         check("vec_valid", bus32.out_valid, 1'b1);
         check("vec_sum",   bus32.sum,   vt[i].s);
         check("vec_cout",  bus32.c_out, vt[i].co);
         check("vec_flags", bus32.flags, fexp(vt[i].fl));
         step();
         check("vec_no_dup", bus32.out_valid, 1'b0);
      end

      // Back-to-back: 8 transfers, one result per cycle in order
      for (int i = 0; i < 8; i++) begin
         tick32(1'b1, 32'(i), 32'(i), 1'b0, 1'b0, 1'b1, acc);
         if (i >= 1) begin
            check("b2b_valid", bus32.out_valid, 1'b1);
            check("b2b_sum",   bus32.sum,       32'(2 * (i - 1)));
         end
      end
      for (int i = 0; i < 3; i++) tick32(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
      check("b2b_drained", q.size(), 0);

      // Backpressure: fill, stall 3 cycles, release
      tick32(1'b1, 32'd100, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      tick32(1'b1, 32'd101, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) begin
         bus32.in_valid = 1'b1; bus32.a = 32'd102; bus32.b = 32'd1; bus32.out_ready = 1'b0;
         #1;
         check("bp_in_ready",  bus32.in_ready,  1'b0);
         check("bp_out_valid", bus32.out_valid, 1'b1);
         check("bp_hold_sum",  bus32.sum,       32'd101);
         step();
      end
      tick32(1'b1, 32'd102, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      check("bp_accept_after", acc, 1'b1);
      tick32(1'b1, 32'd103, 32'd1, 1'b0, 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) tick32(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
      check("bp_drained", q.size(), 0);

      // Random traffic with random backpressure; source holds unaccepted operands
      hold = 1'b0; v = 1'b0; ra = 0; rb = 0; cin = 0; sub = 0;
      for (int i = 0; i < 600; i++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
               0:       ra = 32'hFFFF_FFFF;
               1:       ra = 32'h8000_0000;
               default: ra = $urandom;
            endcase
            rb  = ($urandom_range(0, 4) == 0) ? ~ra : $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
         end
         ordy = ($urandom_range(0, 2) != 0);
         tick32(v, ra, rb, cin, sub, ordy, acc);
         hold = v && !acc;
      end
      for (int i = 0; i < 4; i++) tick32(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
      check("rnd_drained", q.size(), 0);

      // Reset mid-flight discards in-flight results
      tick32(1'b1, 32'd11, 32'd22, 1'b0, 1'b0, 1'b1, acc);
      tick32(1'b1, 32'd33, 32'd44, 1'b0, 1'b0, 1'b1, acc);
      bus32.in_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      q.delete();
      check("mrst_out_valid", bus32.out_valid, 1'b0);
      check("mrst_in_ready",  bus32.in_ready,  1'b1);
      check("mrst_sum",       bus32.sum,       32'd0);
      check("mrst_flags",     bus32.flags,     4'b0000);
      for (int i = 0; i < 4; i++) begin
         step();
         check("mrst_no_result", bus32.out_valid, 1'b0);
      end

      // 16-bit sweep, STAGES=4 and STAGES=1, out_ready held high
      for (int s = 0; s < NSWEEP; s++) begin
         v   = ($urandom_range(0, 7) != 0);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         bus16a.in_valid = v; bus16a.a = a16; bus16a.b = b16; bus16a.c_in = cin; bus16a.sub = sub;
         bus16b.in_valid = v; bus16b.a = a16; bus16b.b = b16; bus16b.c_in = cin; bus16b.sub = sub;
         hv[s] = v;
         hr[s] = model16(a16, b16, cin, sub);
         step();
         idx = s - 3;
         if (idx >= 0) begin
            check("sw4_valid", bus16a.out_valid, hv[idx]);
            if (hv[idx]) begin
               check("sw4_sum",  bus16a.sum,   hr[idx][15:0]);
               check("sw4_cout", bus16a.c_out, hr[idx][16]);
            end
         end else begin
            check("sw4_fill", bus16a.out_valid, 1'b0);
         end
         check("sw1_valid", bus16b.out_valid, hv[s]);
         if (hv[s]) begin
            check("sw1_sum",  bus16b.sum,   hr[s][15:0]);
            check("sw1_cout", bus16b.c_out, hr[s][16]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Operand width is split into 4-bit lookahead groups. Groups are evaluated across STAGES register stages, and the group carry ripples between stages through registers.
- Uses a valid/ready handshake with full-pipeline stall on backpressure. Optionally produces ARM NZCV flags alongside the result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4.
- STAGES, 2, pipeline register stages (latency); (WIDTH/4) must be divisible by STAGES; STAGES >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in.
- sub  input  1  1: compute a + ~b + c_in (ARM SUB uses c_in=1, SBC uses c_in=C).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB.
- flags  output  4  {N,Z,C,V}; see Optional Feature.

Behaviour:
- Operand preparation: b_eff = sub ? ~b : b.
- Group g (4 bits, g = 0..WIDTH/4-1) computes, from its carry-in:
  - generate/propagate: p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i;
  - full 4-bit lookahead carries c1..c4;
  - sum_i = p_i ^ c_i.
- Stage allocation: GPS = (WIDTH/4)/STAGES groups per stage.
  - Stage k (0..STAGES-1) evaluates groups k*GPS .. k*GPS+GPS-1, chaining group carries combinationally within the stage.
- Per-stage registers hold:
  - valid bit;
  - partial sum bits completed so far;
  - unconsumed upper operand bits (a, b_eff);
  - carry into the next stage;
  - the MSB carry-in (for V).
- Latency: a transfer accepted at edge t (in_valid & in_ready) gives out_valid=1 with its result after edge t+STAGES.
  - STAGES=1 gives a one-cycle registered adder.
- Handshake:
  - stall = out_valid & ~out_ready;
  - in_ready = ~stall;
  - when stall=1, every stage register holds; otherwise all stages advance one step.
  - Bubbles (valid=0) advance like data, so throughput is 1 result/cycle when out_ready=1.
- out_valid, sum, c_out and flags are the last stage's registers and are held stable while stall=1.
- No result is dropped or duplicated. Accepted transfers leave in order, one per out_valid&out_ready edge.
- Arithmetic: result is modulo 2^WIDTH; c_out = carry out of bit WIDTH-1 (no borrow inversion; ARM convention C = NOT borrow).
- Reset:
  - all stage valid bits and data registers clear to 0;
  - out_valid=0, sum=0, c_out=0, flags=0, in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight results; no out_valid pulse for them.
- in_valid while in_ready=0: the operands are not captured; the source must hold them.
- Simultaneous out_ready=1 with a full pipeline and in_valid=1: the output retires and the input enters in the same edge.

Optional Feature:
- Macro: CLA_ADDER_FLAGS_EN.
- Defined: flags = {N = sum[WIDTH-1], Z = (sum==0), C = c_out, V = carry into MSB XOR c_out}, registered with the final stage. Flags follow the same reset and stall rules as sum.
- Undefined: flags is tied to 4'b0000 and no flag logic or MSB-carry pipeline register is generated. sum and c_out are unaffected.

Test Plan:
- Pipeline basics, WIDTH=32, STAGES=2, out_ready=1: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, c_in=0 -> 2 cycles later sum=0, c_out=1, flags=0110 (with _EN).
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, sub=0, c_in=0 -> sum=0x8000_0000, c_out=0, flags=1001.
- Subtract: a=5, b=7, sub=1, c_in=1 -> sum=0xFFFF_FFFE, c_out=0, N=1. Then a=7, b=5 -> sum=2, c_out=1.
- Throughput/backpressure:
  - 8 back-to-back transfers (a=i, b=i) -> results 2i in order.
  - Drop out_ready for 3 cycles while full -> in_ready=0, outputs held; release -> no loss or duplication.
- Reset mid-flight: reset after 2 accepted transfers -> out_valid=0 next cycle, in_ready=1, none of those results appear.
- Sweep: WIDTH=16, STAGES=4 and STAGES=1, 10k random a/b/c_in/sub -> sum/c_out match reference {c_out,sum} = a + b_eff + c_in; latency equals STAGES.
